// File: rtl/rmii_frame_rx_pkg.sv
// Shared definitions for the RMII receive framer: FSM states, CRC-32
// constants, Ethernet header byte offsets and frame size limits.
package rmii_frame_rx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PREAMBLE = 4'd1,
    ST_DST      = 4'd2,
    ST_SRC      = 4'd3,
    ST_ETYPE    = 4'd4,
    ST_LEN      = 4'd5,
    ST_DATA     = 4'd6,
    ST_TAIL     = 4'd7,
    ST_DROP     = 4'd8
  } rx_state_t;

  // Reflected CRC-32 (IEEE 802.3)
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  // Byte offsets of header fields, counted from the first dst-MAC byte
  localparam logic [10:0] OFF_DST   = 11'd0;
  localparam logic [10:0] OFF_SRC   = 11'd6;
  localparam logic [10:0] OFF_ETYPE = 11'd12;
  localparam logic [10:0] OFF_LEN   = 11'd14;
  localparam logic [10:0] OFF_DATA  = 11'd16;
  localparam logic [10:0] OFF_TAIL  = 11'd20;

  // Frame size limits in bytes, dst MAC through FCS
  localparam logic [10:0] MIN_FRAME    = 11'd64;
  localparam logic [10:0] MAX_FRAME    = 11'd1518;
  localparam logic [10:0] BYTE_CNT_MAX = 11'd2047;

  // Select byte idx of a MAC address, byte 0 being the first on the wire
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rmii_frame_rx_crc32_dibit.sv
// Combinational next-state of a reflected CRC-32 register for one RMII
// dibit; bit 0 of the dibit is the earlier bit on the wire.
module crc32_dibit
  import rmii_frame_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  logic [31:0] shift0_s;
  logic [31:0] step0_s;
  logic [31:0] shift1_s;

  assign shift0_s = {1'b0, crc_in[31:1]};
  assign step0_s  = (crc_in[0] ^ dibit[0]) ? (shift0_s ^ CRC_POLY) : shift0_s;
  assign shift1_s = {1'b0, step0_s[31:1]};
  assign crc_out  = (step0_s[0] ^ dibit[1]) ? (shift1_s ^ CRC_POLY) : shift1_s;

endmodule

// File: rtl/rmii_frame_rx.sv
// RMII receive framer: assembles dibits into bytes, strips preamble/SFD,
// filters on destination MAC and EtherType, checks the FCS and presents the
// request length and first data word for one cycle per accepted frame.
module rmii_frame_rx
  import rmii_frame_rx_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'h0,
  parameter logic [15:0] ETHERTYPE = 16'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic [31:0] payload,
  output logic [15:0] length,
  output logic        valid
);

  rx_state_t   state_r;
  logic [31:0] crc_r;
  logic [10:0] byte_cnt_r;
  logic [1:0]  dibit_ph_r;
  logic [5:0]  byte_sr_r;
  logic [15:0] len_sh_r;
  logic [31:0] payload_sh_r;

  logic [31:0] crc_next_s;
  logic [7:0]  byte_s;
  logic        byte_done_s;
  logic [10:0] byte_cnt_inc_s;
  logic [7:0]  dst_byte_s;
  logic [7:0]  etype_byte_s;
  logic        frame_ok_s;

  crc32_dibit u_crc (
    .crc_in  (crc_r),
    .dibit   (rxd),
    .crc_out (crc_next_s)
  );

  // The fourth dibit of a byte completes it together with the three held ones
  assign byte_s      = {rxd, byte_sr_r};
  assign byte_done_s = (dibit_ph_r == 2'd3);

  // Byte counter saturates so oversize frames cannot wrap back into range
  assign byte_cnt_inc_s = (byte_cnt_r == BYTE_CNT_MAX) ? BYTE_CNT_MAX : (byte_cnt_r + 11'd1);

  // Expected header bytes at the current byte position
  assign dst_byte_s   = mac_byte(DST_MAC, 3'(byte_cnt_r - OFF_DST));
  assign etype_byte_s = byte_cnt_r[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];

  // Frame acceptance, evaluated in the first cycle with carrier gone
  assign frame_ok_s = (state_r == ST_TAIL)
                   && (dibit_ph_r == 2'd0)
                   && (byte_cnt_r >= MIN_FRAME)
                   && (byte_cnt_r <= MAX_FRAME)
                   && (crc_r == CRC_RESIDUE);

  // Framer FSM with its counters, CRC register, shadow fields and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      crc_r        <= 32'h0000_0000;
      byte_cnt_r   <= 11'd0;
      dibit_ph_r   <= 2'd0;
      byte_sr_r    <= 6'd0;
      len_sh_r     <= 16'h0000;
      payload_sh_r <= 32'h0000_0000;
      payload      <= 32'h0000_0000;
      length       <= 16'h0000;
      valid        <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (crsdv && (rxd == 2'b01)) begin
            state_r <= ST_PREAMBLE;
          end
        end

        ST_PREAMBLE: begin
          if (!crsdv) begin
            state_r <= ST_IDLE;
          end else if (rxd == 2'b01) begin
            state_r <= ST_PREAMBLE;
          end else if (rxd == 2'b11) begin
            // SFD seen: next dibit is the first bit pair of the dst MAC
            state_r    <= ST_DST;
            byte_cnt_r <= 11'd0;
            dibit_ph_r <= 2'd0;
            crc_r      <= CRC_INIT;
          end else begin
            state_r <= ST_DROP;
          end
        end

        ST_DST, ST_SRC, ST_ETYPE, ST_LEN, ST_DATA, ST_TAIL: begin
          if (!crsdv) begin
            if (frame_ok_s) begin
              payload <= payload_sh_r;
              length  <= len_sh_r;
              valid   <= 1'b1;
            end
            state_r <= ST_IDLE;
          end else begin
            crc_r      <= crc_next_s;
            dibit_ph_r <= dibit_ph_r + 2'd1;
            byte_sr_r  <= {rxd, byte_sr_r[5:2]};
            if (byte_done_s) begin
              byte_cnt_r <= byte_cnt_inc_s;
              case (state_r)
                ST_DST: begin
                  if (byte_s != dst_byte_s) begin
                    state_r <= ST_DROP;
                  end else if (byte_cnt_r == (OFF_SRC - 11'd1)) begin
                    state_r <= ST_SRC;
                  end
                end
                ST_SRC: begin
                  if (byte_cnt_r == (OFF_ETYPE - 11'd1)) begin
                    state_r <= ST_ETYPE;
                  end
                end
                ST_ETYPE: begin
                  if (byte_s != etype_byte_s) begin
                    state_r <= ST_DROP;
                  end else if (byte_cnt_r == (OFF_LEN - 11'd1)) begin
                    state_r <= ST_LEN;
                  end
                end
                ST_LEN: begin
                  len_sh_r <= {len_sh_r[7:0], byte_s};
                  if (byte_cnt_r == (OFF_DATA - 11'd1)) begin
                    state_r <= ST_DATA;
                  end
                end
                ST_DATA: begin
                  payload_sh_r <= {payload_sh_r[23:0], byte_s};
                  if (byte_cnt_r == (OFF_TAIL - 11'd1)) begin
                    state_r <= ST_TAIL;
                  end
                end
                ST_TAIL: begin
                  // pad and FCS only advance the CRC and byte counter
                end
                default: begin
                  state_r <= ST_DROP;
                end
              endcase
            end
          end
        end

        ST_DROP: begin
          if (!crsdv) begin
            state_r <= ST_IDLE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_frame_rx.sv
// Directed bench for rmii_frame_rx: builds Ethernet frames with a bench-side
// CRC-32, serialises them as RMII dibits and checks the accepted requests.
module tb_rmii_frame_rx;

  localparam logic [47:0] TB_DST   = 48'h69695A065491;
  localparam logic [15:0] TB_ETYPE = 16'h88B5;

  logic        clk;
  logic        rst_n;
  logic        crsdv;
  logic [1:0]  rxd;
  logic [31:0] payload;
  logic [15:0] length;
  logic        valid;

  int n_vec;
  int n_miss;
  int pulses;
  int exp_pulses;
  logic [31:0] cap_pl[$];
  logic [15:0] cap_len[$];
  logic [7:0]  fr[$];

  rmii_frame_rx #(
    .DST_MAC   (TB_DST),
    .ETHERTYPE (TB_ETYPE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .crsdv   (crsdv),
    .rxd     (rxd),
    .payload (payload),
    .length  (length),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // record every valid pulse, sampled on the falling edge
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      pulses++;
      cap_pl.push_back(payload);
      cap_len.push_back(length);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] ln,
                             input logic [31:0] dat, input int total, input int flip);
    logic [31:0] c;
    logic [31:0] fcs;
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
    fr.push_back(8'h02); fr.push_back(8'h00); fr.push_back(8'h00);
    fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h01);
    fr.push_back(et[15:8]);   fr.push_back(et[7:0]);
    fr.push_back(ln[15:8]);   fr.push_back(ln[7:0]);
    fr.push_back(dat[31:24]); fr.push_back(dat[23:16]);
    fr.push_back(dat[15:8]);  fr.push_back(dat[7:0]);
    while (fr.size() < total - 4) fr.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = crc_byte(c, fr[i]);
    fcs = ~c;
    if (flip >= 0) fcs[flip] = ~fcs[flip];
    fr.push_back(fcs[7:0]);   fr.push_back(fcs[15:8]);
    fr.push_back(fcs[23:16]); fr.push_back(fcs[31:24]);
  endtask

  task automatic drive(input logic c, input logic [1:0] d);
    @(negedge clk);
    crsdv = c;
    rxd   = d;
  endtask

  // preamble + SFD, frame bytes LSB dibit first, then carrier drop
  task automatic send_frame(input int drop_dibits, input int rst_at);
    int last;
    logic [7:0] b;
    last = fr.size() * 4 - drop_dibits;
    for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_payload", payload, 32'h0);
        check("rst_length", {16'h0, length}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
      end
      b = fr[i];
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k < last) drive(1'b1, b[2*k +: 2]);
      end
    end
    drive(1'b0, 2'b00);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic expect_reject(input string tag);
    idle_cycles(4);
    check(tag, pulses, exp_pulses);
    check({tag, "_payload"}, payload, 32'h00110000);
    check({tag, "_length"}, {16'h0, length}, 32'h2);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; pulses = 0; exp_pulses = 0;
    rst_n = 1'b0; crsdv = 1'b0; rxd = 2'b00;
    idle_cycles(3);
    rst_n = 1'b1;
    check("reset_payload", payload, 32'h0);
    check("reset_length", {16'h0, length}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    idle_cycles(2);

    // good write frame: valid exactly on the cycle after carrier drop
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'h1234ABCD, 64, -1);
    send_frame(0, -1);
    @(negedge clk);
    check("write_valid", {31'h0, valid}, 32'h1);
    check("write_payload", payload, 32'h1234ABCD);
    check("write_length", {16'h0, length}, 32'h4);
    @(negedge clk);
    check("write_valid_drop", {31'h0, valid}, 32'h0);
    exp_pulses++;
    idle_cycles(3);
    check("write_pulses", pulses, exp_pulses);

    // read frame
    build_frame(TB_DST, TB_ETYPE, 16'h0002, 32'h00110000, 64, -1);
    send_frame(0, -1);
    @(negedge clk);
    check("read_valid", {31'h0, valid}, 32'h1);
    check("read_payload", payload, 32'h00110000);
    check("read_length", {16'h0, length}, 32'h2);
    exp_pulses++;
    idle_cycles(3);
    check("read_pulses", pulses, exp_pulses);

    // filters
    build_frame(48'h69695A065492, TB_ETYPE, 16'h0004, 32'hDEADBEEF, 64, -1);
    send_frame(0, -1);
    expect_reject("bad_dst");
    build_frame(TB_DST, 16'h0800, 16'h0004, 32'hDEADBEEF, 64, -1);
    send_frame(0, -1);
    expect_reject("bad_etype");
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'hDEADBEEF, 64, 5);
    send_frame(0, -1);
    expect_reject("bad_fcs");

    // size limits
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'hCAFEF00D, 60, -1);
    send_frame(0, -1);
    expect_reject("short_60");
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'hCAFEF00D, 1519, -1);
    send_frame(0, -1);
    expect_reject("long_1519");
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'hCAFEF00D, 64, -1);
    send_frame(1, -1);
    expect_reject("odd_dibit");

    // upper size boundary still accepted
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'h76543210, 1518, -1);
    send_frame(0, -1);
    @(negedge clk);
    check("max_valid", {31'h0, valid}, 32'h1);
    check("max_payload", payload, 32'h76543210);
    exp_pulses++;
    idle_cycles(3);

    // back-to-back with one idle cycle between frames
    cap_pl.delete(); cap_len.delete();
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'hAAAA5555, 64, -1);
    send_frame(0, -1);
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'h0F0F0F0F, 64, -1);
    send_frame(0, -1);
    exp_pulses += 2;
    idle_cycles(4);
    check("b2b_pulses", pulses, exp_pulses);
    check("b2b_count", cap_pl.size(), 2);
    if (cap_pl.size() == 2) begin
      check("b2b_first", cap_pl[0], 32'hAAAA5555);
      check("b2b_second", cap_pl[1], 32'h0F0F0F0F);
      check("b2b_len", {16'h0, cap_len[1]}, 32'h4);
    end

    // reset during the second data byte
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'h9934C3D7, 64, -1);
    send_frame(0, 17);
    idle_cycles(4);
    check("rst_frame_pulses", pulses, exp_pulses);
    check("rst_frame_payload", payload, 32'h0);
    build_frame(TB_DST, TB_ETYPE, 16'h0004, 32'h5A5A0001, 64, -1);
    send_frame(0, -1);
    @(negedge clk);
    check("post_rst_valid", {31'h0, valid}, 32'h1);
    check("post_rst_payload", payload, 32'h5A5A0001);
    check("post_rst_length", {16'h0, length}, 32'h4);
    exp_pulses++;
    idle_cycles(3);
    check("final_pulses", pulses, exp_pulses);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
